lidar_bbox_sequencer: RTL

- Streaming controller in the LiDAR Feature Extractor.
- Consumes one cluster's points at a time from the clustering stage and tracks per-axis min/max in Q16.16.
- On the cluster's last point, drives the shared feature calculator (centroid + dimension) and registers its result.
- Presents one feature record per cluster downstream over a valid/ready handshake; clusters with too few points are dropped and counted.

---
 rtl/lidar_feat_pkg.sv | 42 ++++
 rtl/lidar_bbox_sequencer_feature_calc.sv | 41 ++++
 rtl/lidar_bbox_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lidar_feat_pkg.sv
// Shared types for the LiDAR feature extractor: Q16.16 format, point struct,
// bounding-box sequencer state encoding and per-axis min/max helpers.
package lidar_feat_pkg;

  localparam int unsigned Q_W    = 32;
  localparam int unsigned Q_FRAC = 16;

  typedef logic signed [Q_W-1:0] q16_t;

  typedef struct packed {
    q16_t x;
    q16_t y;
    q16_t z;
  } point_q16_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CALC,
    OUT
  } bbox_seq_state_t;

  // Ties keep the current extreme, so equal coordinates never rewrite the register.
  function automatic point_q16_t point_min(point_q16_t cur, point_q16_t p);
    point_q16_t r;
    r = cur;
    if ($signed(p.x) < $signed(cur.x)) r.x = p.x;
    if ($signed(p.y) < $signed(cur.y)) r.y = p.y;
    if ($signed(p.z) < $signed(cur.z)) r.z = p.z;
    return r;
  endfunction

  function automatic point_q16_t point_max(point_q16_t cur, point_q16_t p);
    point_q16_t r;
    r = cur;
    if ($signed(p.x) > $signed(cur.x)) r.x = p.x;
    if ($signed(p.y) > $signed(cur.y)) r.y = p.y;
    if ($signed(p.z) > $signed(cur.z)) r.z = p.z;
    return r;
  endfunction

endpackage

// File: rtl/lidar_bbox_sequencer_feature_calc.sv
// Combinational feature calculator: centroid = floor((min+max)/2), dim = max-min.
// Dimensions that do not fit in signed Q16.16 raise error_o; the raw low bits are still output.
module FeatureCalculator
  import lidar_feat_pkg::*;
(
  input  point_q16_t min_i,
  input  point_q16_t max_i,
  output point_q16_t centroid_o,
  output point_q16_t dim_o,
  output logic       error_o
);

  logic signed [Q_W:0] sum_x, sum_y, sum_z;
  logic signed [Q_W:0] dif_x, dif_y, dif_z;

  function automatic logic signed [Q_W:0] sext(q16_t v);
    return {v[Q_W-1], v};
  endfunction

  // One guard bit keeps the sum exact, so the centroid itself can never overflow.
  always_comb begin
    sum_x = sext(max_i.x) + sext(min_i.x);
    sum_y = sext(max_i.y) + sext(min_i.y);
    sum_z = sext(max_i.z) + sext(min_i.z);
    dif_x = sext(max_i.x) - sext(min_i.x);
    dif_y = sext(max_i.y) - sext(min_i.y);
    dif_z = sext(max_i.z) - sext(min_i.z);

    centroid_o.x = Q_W'(sum_x >>> 1);
    centroid_o.y = Q_W'(sum_y >>> 1);
    centroid_o.z = Q_W'(sum_z >>> 1);
    dim_o.x      = Q_W'(dif_x);
    dim_o.y      = Q_W'(dif_y);
    dim_o.z      = Q_W'(dif_z);

    error_o = (dif_x[Q_W] ^ dif_x[Q_W-1]) |
              (dif_y[Q_W] ^ dif_y[Q_W-1]) |
              (dif_z[Q_W] ^ dif_z[Q_W-1]);
  end

endmodule

// File: rtl/lidar_bbox_sequencer.sv
// Streams one cluster's points, tracks the per-axis bounding box and emits one
// feature record per accepted cluster over valid/ready; undersized clusters are dropped and counted.
module lidar_bbox_sequencer
  import lidar_feat_pkg::*;
#(
  parameter int unsigned MIN_POINTS = 3,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [31:0]        pt_x,
  input  logic [31:0]        pt_y,
  input  logic [31:0]        pt_z,
  input  logic               pt_last,
  output logic               feat_valid,
  input  logic               feat_ready,
  output logic [31:0]        centroid_x,
  output logic [31:0]        centroid_y,
  output logic [31:0]        centroid_z,
  output logic [31:0]        dx,
  output logic [31:0]        dy,
  output logic [31:0]        dz,
  output logic               feat_error,
  output logic [COUNT_W-1:0] feat_npts,
  output logic [COUNT_W-1:0] drop_count
);

  localparam logic [COUNT_W-1:0] MIN_PTS_C = COUNT_W'(MIN_POINTS);

  bbox_seq_state_t state_q, state_d;

  point_q16_t         pt;
  point_q16_t         min_q, max_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] drop_q;
  point_q16_t         cen_q, dim_q;
  logic               err_q;
  logic [COUNT_W-1:0] npts_q;

  point_q16_t calc_cen, calc_dim;
  logic       calc_err;
  logic       accept;
  logic       too_small;

  assign pt        = '{x: pt_x, y: pt_y, z: pt_z};
  assign accept    = pt_valid && pt_ready;
  assign too_small = cnt_q < MIN_PTS_C;

  FeatureCalculator u_calc (
    .min_i      (min_q),
    .max_i      (max_q),
    .centroid_o (calc_cen),
    .dim_o      (calc_dim),
    .error_o    (calc_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pt_ready   = 1'b0;
    feat_valid = 1'b0;
    case (state_q)
      IDLE: begin
        pt_ready = 1'b1;
        if (pt_valid) state_d = pt_last ? CALC : ACCUM;
      end
      ACCUM: begin
        pt_ready = 1'b1;
        if (pt_valid && pt_last) state_d = CALC;
      end
      CALC: state_d = too_small ? IDLE : OUT;
      OUT: begin
        feat_valid = 1'b1;
        if (feat_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q  <= '0;
      max_q  <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      cen_q  <= '0;
      dim_q  <= '0;
      err_q  <= 1'b0;
      npts_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            min_q <= pt;
            max_q <= pt;
            cnt_q <= COUNT_W'(1);
          end
        end
        ACCUM: begin
          if (accept) begin
            min_q <= point_min(min_q, pt);
            max_q <= point_max(max_q, pt);
            if (cnt_q != '1) cnt_q <= cnt_q + COUNT_W'(1);
          end
        end
        CALC: begin
          if (too_small) begin
            if (drop_q != '1) drop_q <= drop_q + COUNT_W'(1);
          end else begin
            cen_q  <= calc_cen;
            dim_q  <= calc_dim;
            err_q  <= calc_err;
            npts_q <= cnt_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign centroid_x = cen_q.x;
  assign centroid_y = cen_q.y;
  assign centroid_z = cen_q.z;
  assign dx         = dim_q.x;
  assign dy         = dim_q.y;
  assign dz         = dim_q.z;
  assign feat_error = err_q;
  assign feat_npts  = npts_q;
  assign drop_count = drop_q;

endmodule
